// File: rtl/datamover_loopback_checker.sv
// Loopback checker for a DataMover: writes a counting pattern to DDR through S2MM,
// reads it back through MM2S and counts mismatching beats, for a number of iterations.
module datamover_loopback_checker #(
    parameter int DDR_ADDR_WIDTH = 40,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_start,
    input  logic [15:0]                   i_length,
    input  logic [DDR_ADDR_WIDTH-1:0]     i_start_addr,
    input  logic [DDR_ADDR_WIDTH-1:0]     i_addr_stride,
    input  logic [15:0]                   i_iterations,
    input  logic                          i_s2mm_wr_cmd_tready,
    output logic [40+DDR_ADDR_WIDTH-1:0]  o_s2mm_wr_cmd_tdata,
    output logic                          o_s2mm_wr_cmd_tvalid,
    output logic [DATA_WIDTH-1:0]         o_s2mm_wr_tdata,
    output logic [DATA_WIDTH/8-1:0]       o_s2mm_wr_tkeep,
    output logic                          o_s2mm_wr_tvalid,
    output logic                          o_s2mm_wr_tlast,
    input  logic                          i_s2mm_wr_tready,
    input  logic [7:0]                    i_s2mm_sts_tdata,
    input  logic                          i_s2mm_sts_tvalid,
    input  logic                          i_mm2s_rd_cmd_tready,
    output logic [40+DDR_ADDR_WIDTH-1:0]  o_mm2s_rd_cmd_tdata,
    output logic                          o_mm2s_rd_cmd_tvalid,
    input  logic [DATA_WIDTH-1:0]         i_mm2s_rd_tdata,
    input  logic                          i_mm2s_rd_tvalid,
    input  logic                          i_mm2s_rd_tlast,
    output logic                          o_mm2s_rd_tready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_pass,
    output logic [31:0]                   o_err_cnt,
    output logic [15:0]                   o_iter_cnt,
    output logic [2:0]                    o_err_code
);

    // state   | meaning
    // IDLE    | waiting for a start edge
    // WR_CMD  | S2MM command offered
    // WR_DATA | streaming pattern beats to S2MM
    // WR_STS  | waiting for S2MM status
    // RD_CMD  | MM2S command offered
    // RD_DATA | receiving and checking read beats
    // NEXT    | iteration complete, advance address
    // DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE, WR_CMD, WR_DATA, WR_STS, RD_CMD, RD_DATA, NEXT, DONE
    } state_t;

    localparam int BPB   = DATA_WIDTH / 8;
    localparam int LANES = DATA_WIDTH / 32;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t state, state_nx;

    logic                      start_q;
    logic [15:0]               len_r;
    logic [15:0]               iters_r;
    logic [DDR_ADDR_WIDTH-1:0] stride_r;
    logic [DDR_ADDR_WIDTH-1:0] addr_r;
    logic [15:0]               byte_cnt;
    logic [15:0]               word_base;
    logic [TMR_W-1:0]          tmr;
    logic                      done_seen;

    logic                      start_ok;
    logic                      param_bad;
    logic                      last_beat;
    logic                      more_iters;
    logic                      wr_fire;
    logic                      rd_fire;
    logic                      rd_bad;
    logic                      sts_good;
    logic                      sts_bad;
    logic                      timeout_hit;
    logic [DATA_WIDTH-1:0]     pattern;
    logic [40+DDR_ADDR_WIDTH-1:0] cmd_word;

    assign start_ok  = i_start & ~start_q & (state == IDLE);
    assign param_bad = (i_length == 16'd0) || ((i_length % 16'(BPB)) != 16'd0)
                       || (i_iterations == 16'd0);
    assign last_beat  = ({1'b0, byte_cnt} + 17'(BPB)) == {1'b0, len_r};
    assign more_iters = ({1'b0, o_iter_cnt} + 17'd1) != {1'b0, iters_r};
    assign wr_fire    = (state == WR_DATA) & i_s2mm_wr_tready;
    assign rd_fire    = (state == RD_DATA) & i_mm2s_rd_tvalid;
    assign rd_bad     = rd_fire & ((i_mm2s_rd_tdata != pattern) | (i_mm2s_rd_tlast & ~last_beat));
    assign sts_good   = i_s2mm_sts_tvalid & i_s2mm_sts_tdata[7] & (i_s2mm_sts_tdata[6:4] == 3'd0)
                        & (i_s2mm_sts_tdata[3:0] == o_iter_cnt[3:0]);
    assign sts_bad    = (state == WR_STS) & i_s2mm_sts_tvalid & ~sts_good;
    assign timeout_hit = (tmr == '0) & (((state == WR_STS) & ~i_s2mm_sts_tvalid)
                                      | ((state == RD_DATA) & ~i_mm2s_rd_tvalid));

    // Lane j of the current beat carries {iteration, running 32-bit word index}.
    always_comb begin
        pattern = '0;
        for (int j = 0; j < LANES; j++) begin
            pattern[j*32 +: 32] = {o_iter_cnt, word_base + 16'(j)};
        end
    end

    assign cmd_word = {4'd0, o_iter_cnt[3:0], addr_r, 1'b0, 1'b1, 6'd0, 1'b1, 7'd0, len_r};
    assign o_s2mm_wr_cmd_tdata = cmd_word;
    assign o_mm2s_rd_cmd_tdata = cmd_word;
    assign o_s2mm_wr_tdata     = pattern;
    assign o_s2mm_wr_tkeep     = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = param_bad ? DONE : WR_CMD;
            WR_CMD:  if (i_s2mm_wr_cmd_tready) state_nx = WR_DATA;
            WR_DATA: if (wr_fire && last_beat) state_nx = WR_STS;
            WR_STS: begin
                if (sts_good)                      state_nx = RD_CMD;
                else if (sts_bad || timeout_hit)   state_nx = DONE;
            end
            RD_CMD:  if (i_mm2s_rd_cmd_tready) state_nx = RD_DATA;
            RD_DATA: begin
                if (rd_fire && i_mm2s_rd_tlast) state_nx = NEXT;
                else if (timeout_hit)           state_nx = DONE;
            end
            NEXT:    state_nx = more_iters ? WR_CMD : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_s2mm_wr_cmd_tvalid = (state == WR_CMD);
        o_s2mm_wr_tvalid     = (state == WR_DATA);
        o_s2mm_wr_tlast      = (state == WR_DATA) & last_beat;
        o_mm2s_rd_cmd_tvalid = (state == RD_CMD);
        o_mm2s_rd_tready     = (state == RD_DATA);
        o_busy               = (state != IDLE);
        o_done               = (state == DONE);
        o_pass               = ((state == DONE) | done_seen) & (o_err_cnt == 32'd0)
                               & (o_err_code == 3'd0);
    end

    // start_q resets high so a level held through reset is not taken as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b1;
            len_r      <= '0;
            iters_r    <= '0;
            stride_r   <= '0;
            addr_r     <= '0;
            byte_cnt   <= '0;
            word_base  <= '0;
            tmr        <= '0;
            done_seen  <= 1'b0;
            o_err_cnt  <= '0;
            o_iter_cnt <= '0;
            o_err_code <= '0;
        end else begin
            start_q <= i_start;

            if (start_ok) begin
                len_r      <= i_length;
                iters_r    <= i_iterations;
                stride_r   <= i_addr_stride;
                addr_r     <= i_start_addr;
                done_seen  <= 1'b0;
                o_err_cnt  <= '0;
                o_iter_cnt <= '0;
                o_err_code <= param_bad ? 3'd1 : 3'd0;
            end else begin
                if (state == DONE)   done_seen <= 1'b1;
                if (sts_bad)         o_err_code <= 3'd2;
                if (timeout_hit)     o_err_code <= 3'd3;
                if (rd_bad && (o_err_cnt != 32'hFFFF_FFFF)) o_err_cnt <= o_err_cnt + 32'd1;
                if (state == NEXT) begin
                    o_iter_cnt <= o_iter_cnt + 16'd1;
                    addr_r     <= addr_r + stride_r;
                end
            end

            if ((state == WR_CMD) || (state == RD_CMD)) begin
                byte_cnt  <= '0;
                word_base <= '0;
            end else if (wr_fire || rd_fire) begin
                byte_cnt  <= byte_cnt + 16'(BPB);
                word_base <= word_base + 16'(LANES);
            end

            // Progress timer: reloads on any state change or accepted read beat.
            if ((state_nx != state) || rd_fire) tmr <= TMR_W'(TIMEOUT_CYCLES);
            else if (tmr != '0)                 tmr <= tmr - 1'b1;
        end
    end

endmodule
